// File: rtl/dmem_pkg.sv
// Shared types and default constants for the test-completion data memory responder.
// Verdict encoding plus the default memory geometry and mailbox/scratch addresses.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } verdict_e;

    localparam int unsigned DEPTH        = 64;
    localparam int unsigned MAILBOX_ADDR = 84;
    localparam int unsigned SCRATCH_ADDR = 80;
    localparam logic [31:0] PASS_VALUE   = 32'd7;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory bus: strobes, address and data out; read data and verdict back.
// No handshake: each strobe is consumed in the cycle it is presented.
interface dmem_responder_if;

    logic        mem_write;
    logic        mem_read;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        fault;
    logic [15:0] write_count;

    modport master (
        output mem_write, mem_read, data_addr, write_data,
        input  read_data, done, pass, fail, fault, write_count
    );

    modport slave (
        input  mem_write, mem_read, data_addr, write_data,
        output read_data, done, pass, fail, fault, write_count
    );

endinterface

// File: rtl/dmem_array.sv
// Word RAM, one synchronous write port and one asynchronous read port on a shared index.
// Read is zero-latency and returns the pre-edge word; no backpressure.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdat_i,
    output logic [31:0]      rdat_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data memory with a mailbox-driven pass/fail verdict, sticky fault flag and write counter.
// Reads combinational, verdict visible one cycle after the deciding write; no backpressure.
module dmem_responder #(
    parameter int unsigned DEPTH        = dmem_pkg::DEPTH,
    parameter int unsigned MAILBOX_ADDR = dmem_pkg::MAILBOX_ADDR,
    parameter int unsigned SCRATCH_ADDR = dmem_pkg::SCRATCH_ADDR,
    parameter logic [31:0] PASS_VALUE   = dmem_pkg::PASS_VALUE
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    import dmem_pkg::*;

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH);

    verdict_e    state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic             addr_ok;
    logic             wr_acc;
    logic             is_mailbox;
    logic             is_scratch;
    logic [IDX_W-1:0] idx;
    logic [31:0]      ram_rdat;

    assign addr_ok    = (bus.data_addr[1:0] == 2'b00) && (bus.data_addr < BYTE_LIMIT);
    assign idx        = bus.data_addr[IDX_W+1:2];
    assign is_mailbox = (bus.data_addr == 32'(MAILBOX_ADDR));
    assign is_scratch = (bus.data_addr == 32'(SCRATCH_ADDR));
    // Writes presented while reset is held must not reach the RAM, which itself has no reset.
    assign wr_acc     = bus.mem_write && addr_ok && reset;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (wr_acc),
        .idx_i  (idx),
        .wdat_i (bus.write_data),
        .rdat_o (ram_rdat)
    );

    assign bus.read_data = (bus.mem_read && addr_ok) ? ram_rdat : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;

        if ((bus.mem_read && bus.mem_write) ||
            ((bus.mem_read || bus.mem_write) && !addr_ok)) begin
            fault_d = 1'b1;
        end

        if (wr_acc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        // Only the first non-scratch write decides; PASS and FAIL are terminal.
        if (bus.mem_write && (state_q == ST_RUN)) begin
            if (wr_acc && is_mailbox && (bus.write_data == PASS_VALUE)) begin
                state_d = ST_PASS;
            end else if (!is_scratch) begin
                state_d = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign bus.done        = (state_q != ST_RUN);
    assign bus.pass        = (state_q == ST_PASS);
    assign bus.fail        = (state_q == ST_FAIL);
    assign bus.fault       = fault_q;
    assign bus.write_count = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scenarios, random traffic and counter saturation against a behavioural model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: verdict as 0=running, 1=passed, 2=failed.
    logic [31:0] m_mem   [64];
    bit          m_known [64];
    int          m_verdict;
    bit          m_fault;
    int          m_cnt;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "/done"},  {31'd0, bus.done},  {31'd0, m_verdict != 0});
        chk({tag, "/pass"},  {31'd0, bus.pass},  {31'd0, m_verdict == 1});
        chk({tag, "/fail"},  {31'd0, bus.fail},  {31'd0, m_verdict == 2});
        chk({tag, "/fault"}, {31'd0, bus.fault}, {31'd0, m_fault});
        chk({tag, "/wcnt"},  {16'd0, bus.write_count}, 32'(m_cnt));
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    task automatic model_edge(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = addr_valid(a);
        if ((w && r) || ((w || r) && !ok)) m_fault = 1'b1;
        if (w) begin
            if (ok) begin
                m_mem[a / 4]   = d;
                m_known[a / 4] = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (m_verdict == 0) begin
                if (ok && a == 84 && d == 7) m_verdict = 1;
                else if (a != 80)            m_verdict = 2;
            end
        end
    endtask

    // Starts just after a rising edge; checks read data before the edge, verdict after it.
    task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        bus.mem_write  = w;
        bus.mem_read   = r;
        bus.data_addr  = a;
        bus.write_data = d;
        #2;
        if (!r || !addr_valid(a))
            chk({tag, "/rd"}, bus.read_data, 32'd0);
        else if (m_known[a / 4])
            chk({tag, "/rd"}, bus.read_data, m_mem[a / 4]);
        model_edge(w, r, a, d);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        chk_state(tag);
    endtask

    // Asserts reset mid-cycle and checks the flags clear before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m_verdict = 0;
        m_fault   = 1'b0;
        m_cnt     = 0;
        chk_state(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        m_verdict = 0;
        m_fault   = 1'b0;
        m_cnt     = 0;

        // Write strobe held through reset must be ignored.
        reset          = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.data_addr  = 32'd84;
        bus.write_data = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        chk_state("in_reset");
        bus.mem_write = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        chk_state("after_release");

        // Scratch write, read-back, then passing mailbox write.
        txn(1, 0, 32'd80, 32'd5, "w80");
        txn(0, 1, 32'd80, 32'd0, "r80");
        txn(1, 0, 32'd84, 32'd7, "w84_pass");
        txn(1, 0, 32'd252, 32'hDEAD_BEEF, "w252_last");
        txn(0, 1, 32'd252, 32'd0, "r252_last");
        txn(1, 0, 32'd256, 32'd1, "w256_oor");
        txn(0, 1, 32'd256, 32'd0, "r256_oor");
        txn(0, 1, 32'd84, 32'd0, "r84_pass");
        do_reset("rst_in_pass");
        txn(0, 1, 32'd84, 32'd0, "r84_after_rst");

        // Wrong mailbox value fails, and fail is terminal.
        txn(1, 0, 32'd84, 32'd6, "w84_bad");
        txn(1, 0, 32'd84, 32'd7, "w84_late");

        // Misaligned write: fault, fail, RAM untouched.
        do_reset("rst_c");
        txn(1, 0, 32'h52, 32'd9, "w52_misal");
        txn(0, 1, 32'd80, 32'd0, "r80_unchanged");
        txn(0, 1, 32'h53, 32'd0, "r53_misal");

        // Simultaneous read+write of the mailbox returns the old word.
        do_reset("rst_d1");
        txn(1, 0, 32'd84, 32'd3, "w84_3");
        do_reset("rst_d2");
        txn(1, 1, 32'd84, 32'd7, "rw84");
        txn(0, 1, 32'd84, 32'd0, "r84_new");

        // Random traffic in several episodes.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset($sformatf("rst_ep%0d", ep));
            for (int i = 0; i < 60; i++) begin
                int          cat;
                bit          w, r;
                logic [31:0] a, d;
                cat = $urandom_range(0, 19);
                w   = ($urandom_range(0, 2) == 0);
                r   = ($urandom_range(0, 1) == 0);
                d   = $urandom;
                if (cat < 8)       a = 32'd80;
                else if (cat < 10) begin
                    a = 32'd84;
                    if ($urandom_range(0, 1) == 0) d = 32'd7;
                end
                else if (cat < 16) a = 32'($urandom_range(0, 63)) * 4;
                else if (cat < 18) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                else               a = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
                txn(w, r, a, d, $sformatf("rnd%0d_%0d", ep, i));
            end
        end

        // Write counter saturation.
        do_reset("rst_sat");
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.data_addr  = 32'd80;
        bus.write_data = 32'd1;
        for (int i = 0; i < 65535; i++) begin
            model_edge(1, 0, 32'd80, 32'd1);
            @(posedge clk);
        end
        #1;
        chk_state("sat_exact");
        for (int i = 0; i < 3; i++) begin
            model_edge(1, 0, 32'd80, 32'd1);
            @(posedge clk);
        end
        #1;
        bus.mem_write = 1'b0;
        chk_state("sat_hold");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
